// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the telemetry frame sequencer and its UART serializer.
// Delimiter constants are also used by the upstream byte multiplexer.
package uart_frame_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_FETCH = 3'd2,
      ST_START = 3'd3,
      ST_DATA  = 3'd4,
      ST_STOP  = 3'd5
   } state_t;

   localparam int FRAME_LEN_DEF = 37;

   localparam logic [7:0] ASCII_LPAREN = 8'h28;
   localparam logic [7:0] ASCII_RPAREN = 8'h29;
   localparam logic [7:0] ASCII_DOT    = 8'h2E;

   function automatic int calc_baud_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

   // Counter width for a 0..n-1 range, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first: start bit follows load by one cycle, 10*BAUD_DIV cycles per byte.
// No backpressure; load is only issued while idle, done_o strobes during the final stop-bit cycle.
module uart_tx_byte
   import uart_frame_pkg::*;
#(
   parameter int BAUD_DIV = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic [7:0] data_i,
   output logic       tx_o,
   output logic       done_o
);

   localparam int            CW        = cnt_width(BAUD_DIV);
   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          baud_end;

   assign baud_end = (baud_q == BAUD_LAST);
   assign tx_o     = tx_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      done_o  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
         end
         ST_START: begin
            if (baud_end) begin
               state_d = ST_DATA;
               baud_d  = '0;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         ST_STOP: begin
            if (baud_end) begin
               state_d = ST_IDLE;
               baud_d  = '0;
               done_o  = 1'b1;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            baud_d  = '0;
            tx_d    = 1'b1;
         end
      endcase

      // The line drops at the same edge that captures the byte, so the start bit is registered.
      if (load_i) begin
         state_d = ST_START;
         baud_d  = '0;
         bit_d   = '0;
         shift_d = data_i;
         tx_d    = 1'b0;
      end
   end

endmodule

// File: rtl/uart_frame_tx.sv
// Frame sequencer: walks byte_idx over the frame, fetches each mux byte and sends it as 8N1 UART.
// Start bit 3 cycles after trigger, 2+10*BAUD_DIV cycles per byte; triggers while busy are dropped.
module uart_frame_tx
   import uart_frame_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int FRAME_LEN  = FRAME_LEN_DEF,
   parameter int PERIOD_CYC = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_req,
   input  logic [7:0] frame_byte,
   output logic [7:0] byte_idx,
   output logic       uart_tx,
   output logic       busy,
   output logic       frame_done
);

   localparam int            BAUD_DIV    = calc_baud_div(CLK_FREQ, BAUD);
   localparam int            TW          = cnt_width(PERIOD_CYC);
   localparam logic [TW-1:0] PERIOD_LAST = TW'(PERIOD_CYC - 1);
   localparam logic [7:0]    IDX_LAST    = 8'(FRAME_LEN - 1);

   state_t        state_q, state_d;
   logic [7:0]    idx_q, idx_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          tick;
   logic          trigger;
   logic          ser_load;
   logic          ser_done;
   logic          ser_tx;

   assign tick    = (PERIOD_CYC != 0) && (timer_q == PERIOD_LAST);
   assign trigger = frame_req | tick;

   assign byte_idx   = idx_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign uart_tx    = ser_tx;

   always_comb begin
      timer_d = '0;
      if ((PERIOD_CYC != 0) && !tick) begin
         timer_d = timer_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         timer_q <= timer_d;
      end
   end

   // START..STOP sequencing lives in uart_tx_byte; here ST_START means "serializer owns the line".
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      ser_load = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (trigger) begin
               state_d = ST_SETUP;
               busy_d  = 1'b1;
               idx_d   = '0;
            end
         end
         ST_SETUP: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            ser_load = 1'b1;
            state_d  = ST_START;
         end
         ST_START: begin
            if (ser_done) begin
               if (idx_q == IDX_LAST) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  idx_d   = '0;
               end else begin
                  state_d = ST_SETUP;
                  idx_d   = idx_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            idx_d   = '0;
         end
      endcase
   end

   uart_tx_byte #(
      .BAUD_DIV(BAUD_DIV)
   ) u_tx_byte (
      .clk   (clk),
      .rst_n (rst_n),
      .load_i(ser_load),
      .data_i(frame_byte),
      .tx_o  (ser_tx),
      .done_o(ser_done)
   );

endmodule
